// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Bit positions inside the one-hot opcode class vector
    localparam int unsigned NUM_CLASS = 9;
    localparam int unsigned CL_R      = 0;
    localparam int unsigned CL_IALU   = 1;
    localparam int unsigned CL_LOAD   = 2;
    localparam int unsigned CL_STORE  = 3;
    localparam int unsigned CL_BRANCH = 4;
    localparam int unsigned CL_JAL    = 5;
    localparam int unsigned CL_JALR   = 6;
    localparam int unsigned CL_LUI    = 7;
    localparam int unsigned CL_AUIPC  = 8;

    // ALUOp encodings
    localparam logic [2:0] ALUOP_R     = 3'b000;
    localparam logic [2:0] ALUOP_I     = 3'b001;
    localparam logic [2:0] ALUOP_STORE = 3'b010;
    localparam logic [2:0] ALUOP_BR    = 3'b011;
    localparam logic [2:0] ALUOP_U     = 3'b100;
    localparam logic [2:0] ALUOP_JAL   = 3'b101;
    localparam logic [2:0] ALUOP_LOAD  = 3'b110;
    localparam logic [2:0] ALUOP_JALR  = 3'b111;

    // PC source mux
    localparam logic [1:0] PCSRC_PC4       = 2'b00;
    localparam logic [1:0] PCSRC_OLDPC_IMM = 2'b01;
    localparam logic [1:0] PCSRC_ALU       = 2'b10;

    // Register write-back source
    localparam logic [1:0] RDSEL_ALU       = 2'b00;
    localparam logic [1:0] RDSEL_IMM_MEM   = 2'b01;
    localparam logic [1:0] RDSEL_PC4       = 2'b10;
    localparam logic [1:0] RDSEL_OLDPC_IMM = 2'b11;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_opclass_dec.sv
// Maps a 7-bit opcode onto a one-hot instruction class and a legal flag.
module mc_opclass_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [8:0] opclass,
    output logic       legal
);

    // One-hot class lookup; anything outside the nine majors is illegal
    always_comb begin
        opclass = 9'b0;
        case (opcode)
            OP_R:      opclass[CL_R]      = 1'b1;
            OP_IALU:   opclass[CL_IALU]   = 1'b1;
            OP_LOAD:   opclass[CL_LOAD]   = 1'b1;
            OP_STORE:  opclass[CL_STORE]  = 1'b1;
            OP_BRANCH: opclass[CL_BRANCH] = 1'b1;
            OP_JAL:    opclass[CL_JAL]    = 1'b1;
            OP_JALR:   opclass[CL_JALR]   = 1'b1;
            OP_LUI:    opclass[CL_LUI]    = 1'b1;
            OP_AUIPC:  opclass[CL_AUIPC]  = 1'b1;
            default:   opclass = 9'b0;
        endcase
        legal = |opclass;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath.
// Strobes are decoded from the registered state and latched opcode class;
// the memory-side strobes also follow mem_ready/branch_taken in the same cycle.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemReq,
    output logic       MemWE,
    output logic       IorD,
    output logic [2:0] ALUOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic [1:0] rdsel,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    // Wait-counter value seen during the last allowed request cycle
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [8:0] class_q, class_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;

    logic [8:0] dec_class_s;
    logic       dec_legal_s;
    logic       expire_s;

    mc_opclass_dec u_dec (
        .opcode  (Opcode),
        .opclass (dec_class_s),
        .legal   (dec_legal_s)
    );

    assign expire_s = (wait_q == WAIT_LAST);

    // Next-state, wait counter, class latch and trap bookkeeping
    always_comb begin
        state_d = state_q;
        wait_d  = 8'd0;            // clears on any exit or accepted request
        class_d = class_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (expire_s) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                class_d = dec_class_s;
                if (dec_legal_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (class_q[CL_LOAD] || class_q[CL_STORE]) begin
                    state_d = ST_MEM;
                end else if (class_q[CL_BRANCH] || class_q[CL_JAL] || class_q[CL_JALR]) begin
                    state_d = ST_FETCH;
                end else if (class_q != 9'b0) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = class_q[CL_STORE] ? ST_FETCH : ST_WB;
                end else if (expire_s) begin
                    state_d = ST_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath strobes; reset forces the FETCH request pattern with no writes
    always_comb begin
        PCWrite    = 1'b0;
        PCSrc      = PCSRC_PC4;
        IRWrite    = 1'b0;
        MemReq     = 1'b0;
        MemWE      = 1'b0;
        IorD       = 1'b0;
        ALUOp      = ALUOP_R;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        rdsel      = RDSEL_ALU;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;
        if (!rst_n) begin
            MemReq = 1'b1;
        end else begin
            trap       = trap_q;
            trap_cause = cause_q;
            case (state_q)
                ST_FETCH: begin
                    MemReq  = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                ST_EXEC: begin
                    if (class_q[CL_R]) begin
                        ALUOp = ALUOP_R;
                    end else if (class_q[CL_IALU]) begin
                        ALUOp   = ALUOP_I;
                        ALUSrcB = 1'b1;
                    end else if (class_q[CL_LOAD]) begin
                        ALUOp   = ALUOP_LOAD;
                        ALUSrcB = 1'b1;
                    end else if (class_q[CL_STORE]) begin
                        ALUOp   = ALUOP_STORE;
                        ALUSrcB = 1'b1;
                    end else if (class_q[CL_BRANCH]) begin
                        ALUOp   = ALUOP_BR;
                        PCWrite = branch_taken;
                        PCSrc   = PCSRC_OLDPC_IMM;
                        retire  = 1'b1;
                    end else if (class_q[CL_JAL]) begin
                        ALUOp    = ALUOP_JAL;
                        ALUSrcA  = 1'b1;
                        ALUSrcB  = 1'b1;
                        PCWrite  = 1'b1;
                        PCSrc    = PCSRC_OLDPC_IMM;
                        RegWrite = 1'b1;
                        rdsel    = RDSEL_PC4;
                        retire   = 1'b1;
                    end else if (class_q[CL_JALR]) begin
                        ALUOp    = ALUOP_JALR;
                        ALUSrcB  = 1'b1;
                        PCWrite  = 1'b1;
                        PCSrc    = PCSRC_ALU;
                        RegWrite = 1'b1;
                        rdsel    = RDSEL_PC4;
                        retire   = 1'b1;
                    end else if (class_q[CL_LUI]) begin
                        ALUOp   = ALUOP_U;
                        ALUSrcB = 1'b1;
                    end else if (class_q[CL_AUIPC]) begin
                        ALUOp   = ALUOP_U;
                        ALUSrcA = 1'b1;
                        ALUSrcB = 1'b1;
                    end else begin
                        ALUOp = ALUOP_R;
                    end
                end
                ST_MEM: begin
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                    MemWE  = class_q[CL_STORE];
                    retire = mem_ready & class_q[CL_STORE];
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                    if (class_q[CL_LOAD]) begin
                        MemtoReg = 1'b1;
                        rdsel    = RDSEL_IMM_MEM;
                    end else if (class_q[CL_LUI]) begin
                        rdsel = RDSEL_IMM_MEM;
                    end else if (class_q[CL_AUIPC]) begin
                        rdsel = RDSEL_OLDPC_IMM;
                    end else begin
                        rdsel = RDSEL_ALU;
                    end
                end
                default: begin
                    MemReq = 1'b0;
                end
            endcase
        end
    end

    // State, wait counter, latched class and sticky trap registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            wait_q  <= 8'd0;
            class_q <= 9'b0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            class_q <= class_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I datapath. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it drives the datapath strobes (PC/IR write, memory request, ALU operand selects, register write) from the instruction opcode. It waits on a single memory ready handshake and traps on illegal opcodes or memory timeouts. It sits between the instruction register and the shared instruction/data memory port, sequencing the single ALU and the register file.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive request cycles without `mem_ready` before a timeout trap (1..255).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- Opcode  in  7  IR[6:0]; stable from the cycle after IRWrite.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  ALU compare result; valid in EXEC.
- PCWrite  out  1  load PC from the PCSrc mux.
- PCSrc  out  2  00 PC+4, 01 OldPC+imm, 10 ALU result with bit0 cleared.
- IRWrite  out  1  latch the instruction into IR and the current PC into OldPC.
- MemReq  out  1  memory request; held until `mem_ready`.
- MemWE  out  1  store request (qualifies MemReq).
- IorD  out  1  0 = instruction address (PC), 1 = data address (ALUOut).
- ALUOp  out  3  000 R, 001 I-ALU, 010 store, 011 branch, 100 U-type, 101 JAL, 110 load, 111 JALR.
- ALUSrcA  out  1  0 = rs1, 1 = OldPC.
- ALUSrcB  out  1  0 = rs2, 1 = immediate.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  write-back from memory data.
- rdsel  out  2  00 ALUOut, 01 imm/mem, 10 PC+4, 11 OldPC+imm.
- retire  out  1  one-cycle pulse on instruction completion.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs decode from the registered state plus the opcode class. The opcode class is latched in DECODE.
- FETCH: MemReq=1, IorD=0. On `mem_ready`, assert IRWrite, PCWrite and PCSrc=00, then go to DECODE.
- DECODE: latch the class and read the register file. An opcode outside the 9 RV32I majors sends the FSM to TRAP with cause 01.
- EXEC, per class:
  - R / I-ALU / LUI / AUIPC: drive ALUOp and the operand selects, then go to WB.
  - Branch: PCWrite=branch_taken, PCSrc=01, retire, then go to FETCH.
  - JAL: PCWrite=1, PCSrc=01, RegWrite=1, rdsel=10, retire, then go to FETCH.
  - JALR: same as JAL with PCSrc=10.
  - Load / store: compute the address, then go to MEM.
- MEM: MemReq=1, IorD=1, MemWE=store. On `mem_ready`, a store retires and goes to FETCH; a load goes to WB.
- WB: RegWrite=1, one cycle, retire, then go to FETCH.
  - Load: MemtoReg=1, rdsel=01.
  - LUI: rdsel=01.
  - AUIPC: rdsel=11.
  - Otherwise: rdsel=00.
- Wait counter (8 bit): increments each MemReq cycle with `mem_ready` low and clears on `mem_ready` or state exit.
  - If `mem_ready` is low in the MEM_TIMEOUT-th consecutive request cycle, go to TRAP with cause 10.
  - `mem_ready` arriving in that same cycle is accepted.
- TRAP: all strobes 0, trap=1, cause held. TRAP is left only by reset.
- `mem_ready` while MemReq=0 is ignored.

## Timing
- Reset (rst_n low at an edge): state=FETCH, wait counter=0, latched class cleared, trap=0, trap_cause=00. Reset mid-transaction drops the request without any write.
- Output values under reset:
  - MemReq=1, IorD=0, because FETCH drives them from state.
  - All other outputs 0.
- Cycle counts with zero-wait memory:
  - Branch and jumps: 3 cycles.
  - ALU, LUI, AUIPC and store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle adds 1.
- IRWrite and PCWrite in FETCH are single-cycle pulses coincident with `mem_ready`.
- The retire pulse coincides with the final RegWrite or PCWrite cycle.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - the RV32I opcode constants;
  - the ALUOp, PCSrc and rdsel encodings;
  - the trap cause codes.
- Sub-module `mc_opclass_dec` (combinational) maps Opcode to a one-hot class plus a legal flag. Reuse it wherever opcodes are classified.

## Test plan
- ADD (0110011), mem_ready always 1 → IRWrite in cycle 0, RegWrite with rdsel=00 in cycle 3, retire in cycle 3, back in FETCH at cycle 4.
- LW (0000011), data memory ready after 3 wait cycles → MEM lasts 4 cycles, WB with MemtoReg=1 and rdsel=01, 8 cycles total.
- BEQ with branch_taken=1, then again with 0 → PCWrite=1 / PCSrc=01 in EXEC for the first; PCWrite=0 and retire only for the second; 3 cycles each.
- Opcode 1111111 → TRAP after DECODE with trap=1, cause=01; all strobes stay 0 for 20 cycles; rst_n low for one edge returns to FETCH.
- MEM_TIMEOUT=15, fetch with mem_ready low → TRAP with cause=10 after 15 request cycles; a repeat with ready in cycle 15 completes normally.
- rst_n asserted during MEM of a store → MemWE never seen with mem_ready; next cycle state=FETCH, counter=0.
